// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the bus_initiator slice: FSM encoding, phase counter
// width, timing parameter defaults and the counter reload helper.
package bus_initiator_pkg;

    localparam int CNT_W          = 4;
    localparam int SETUP_CYC_DEF  = 1;
    localparam int STROBE_CYC_DEF = 2;
    localparam int HOLD_CYC_DEF   = 1;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // A phase lasting N cycles loads N-1 so the counter reads zero in its last cycle.
    function automatic cnt_t phase_load(input int unsigned cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Phase duration timer: loads a count on state entry, decrements to zero and
// holds there, flagging the last cycle of the current phase.
module bus_phase_timer
    import bus_initiator_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  cnt_t load_val,
    output logic zero
);

    cnt_t cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - cnt_t'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/bus_initiator.sv
// Parallel-bus initiator: IDLE -> SETUP -> STROBE -> HOLD -> DONE sequencing of
// CS_n / WR_n / RD_n and a tri-stated data bus. Define BUS_INITIATOR_WAIT_EN to add
// the WAIT input that stretches the strobe phase.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
    parameter int unsigned STROBE_CYC = STROBE_CYC_DEF,
    parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic       WE,
    input  logic [7:0] WDATA,
    output logic       BUSY,
    output logic       ACK,
    output logic [7:0] RDATA,
    output logic       WR_n,
    output logic       RD_n,
    output logic       CS_n,
    inout  wire  [7:0] DataBus
`ifdef BUS_INITIATOR_WAIT_EN
    ,
    input  logic       WAIT
`endif
);

    state_t     state_q;
    state_t     state_d;
    logic       load;
    cnt_t       load_val;
    logic       timer_zero;
    logic       wait_hold;
    logic       accept;
    logic       strobe_exit;
    logic       busy;
    logic       we_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;

`ifdef BUS_INITIATOR_WAIT_EN
    assign wait_hold = WAIT;
`else
    assign wait_hold = 1'b0;
`endif

    bus_phase_timer u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (load),
        .load_val (load_val),
        .zero     (timer_zero)
    );

    assign accept      = REQ && (state_q == ST_IDLE || state_q == ST_DONE);
    assign strobe_exit = (state_q == ST_STROBE) && timer_zero && !wait_hold;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (REQ) begin
                    state_d  = ST_SETUP;
                    load     = 1'b1;
                    load_val = phase_load(SETUP_CYC);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    state_d  = ST_STROBE;
                    load     = 1'b1;
                    load_val = phase_load(STROBE_CYC);
                end
            end
            ST_STROBE: begin
                if (strobe_exit) begin
                    state_d  = ST_HOLD;
                    load     = 1'b1;
                    load_val = phase_load(HOLD_CYC);
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request attributes are frozen at accept; later host changes do not leak in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= WE;
            wdata_q <= WDATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
        end else if (strobe_exit && !we_q) begin
            rdata_q <= DataBus;
        end
    end

    // Outputs decode the registered state only, so reset reaches the pins at once.
    assign busy    = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    assign BUSY    = busy;
    assign CS_n    = !busy;
    assign WR_n    = !((state_q == ST_STROBE) && we_q);
    assign RD_n    = !((state_q == ST_STROBE) && !we_q);
    assign ACK     = (state_q == ST_DONE);
    assign RDATA   = rdata_q;
    assign DataBus = (busy && we_q) ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: a transfer-timeline model checked every
// cycle, plus directed scenarios with hand-computed cycle positions.
module tb_bus_initiator;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ = 1'b0;
    logic       WE = 1'b0;
    logic [7:0] WDATA = 8'h00;
    logic       BUSY, ACK, WR_n, RD_n, CS_n;
    logic [7:0] RDATA;
    wire  [7:0] DataBus;
    logic [7:0] periph_data = 8'h00;
`ifdef BUS_INITIATOR_WAIT_EN
    logic       wait_drv = 1'b0;
`endif

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    bus_initiator #(
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .HOLD_CYC   (H)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .WE      (WE),
        .WDATA   (WDATA),
        .BUSY    (BUSY),
        .ACK     (ACK),
        .RDATA   (RDATA),
        .WR_n    (WR_n),
        .RD_n    (RD_n),
        .CS_n    (CS_n),
        .DataBus (DataBus)
`ifdef BUS_INITIATOR_WAIT_EN
        ,
        .WAIT    (wait_drv)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- transfer timeline model ----------------
    // m_k counts cycles since the accept edge (1 = first cycle after it);
    // m_ext counts strobe cycles added by WAIT.
    logic       m_active = 1'b0;
    int         m_k = 0;
    int         m_ext = 0;
    logic       m_we = 1'b0;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    logic       wait_eff;
    int         m_len;
    logic       m_in_gap, m_strobe_last, m_extend;
    logic       e_busy, e_strobe, e_ack, e_drive;
    logic [7:0] e_db;

`ifdef BUS_INITIATOR_WAIT_EN
    assign wait_eff = wait_drv;
`else
    assign wait_eff = 1'b0;
`endif

    assign m_len         = S + T + H + 1 + m_ext;
    assign m_in_gap      = !m_active || (m_k == m_len);
    assign m_strobe_last = m_active && (m_k == S + T + m_ext);
    assign m_extend      = m_strobe_last && wait_eff;
    assign e_busy        = m_active && (m_k <= S + T + H + m_ext);
    assign e_strobe      = m_active && (m_k > S) && (m_k <= S + T + m_ext);
    assign e_ack         = m_active && (m_k == m_len);
    assign e_drive       = e_busy && m_we;
    assign e_db          = e_drive ? m_wdata : periph_data;

    // The peripheral drives whenever the initiator must not, so any stray drive shows up.
    assign DataBus = e_drive ? 8'hzz : periph_data;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_ext    <= 0;
            m_we     <= 1'b0;
            m_wdata  <= 8'h00;
            m_rdata  <= 8'h00;
        end else begin
            if (m_strobe_last && !m_extend && !m_we) m_rdata <= periph_data;
            if (m_extend) m_ext <= m_ext + 1;
            if (m_in_gap && REQ) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_ext    <= 0;
                m_we     <= WE;
                m_wdata  <= WDATA;
            end else if (m_in_gap) begin
                m_active <= 1'b0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    int         cs_cnt = 0, wr_cnt = 0, rd_cnt = 0, ack_cnt = 0, db_bad = 0;
    int         wr_start = 0, wr_last = 0, rd_start = 0;
    logic       wr_prev = 1'b1, rd_prev = 1'b1;
    logic       mon_db_chk = 1'b0;
    logic [7:0] mon_db = 8'h00;

    always @(negedge CLK) begin
        check("cyc_busy",  BUSY,    e_busy);
        check("cyc_cs_n",  CS_n,    !e_busy);
        check("cyc_wr_n",  WR_n,    !(e_strobe && m_we));
        check("cyc_rd_n",  RD_n,    !(e_strobe && !m_we));
        check("cyc_ack",   ACK,     e_ack);
        check("cyc_rdata", RDATA,   m_rdata);
        check("cyc_bus",   DataBus, e_db);
        if (!CS_n) cs_cnt <= cs_cnt + 1;
        if (ACK) ack_cnt <= ack_cnt + 1;
        if (!WR_n) begin
            wr_cnt  <= wr_cnt + 1;
            wr_last <= cyc;
            if (wr_prev) wr_start <= cyc;
        end
        if (!RD_n) begin
            rd_cnt <= rd_cnt + 1;
            if (rd_prev) rd_start <= cyc;
        end
        if (mon_db_chk && !CS_n && (DataBus !== mon_db)) db_bad <= db_bad + 1;
        wr_prev <= WR_n;
        rd_prev <= RD_n;
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_xfer(input logic we, input logic [7:0] data, output int acc);
        @(negedge CLK);
        REQ   = 1'b1;
        WE    = we;
        WDATA = data;
        @(posedge CLK);
        #1 acc = cyc;
        @(negedge CLK);
        REQ = 1'b0;
    endtask

    task automatic wait_ack(output int at);
        bit found = 1'b0;
        at = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLK);
            if (ACK) begin
                found = 1'b1;
                at = cyc;
            end
        end
        check("ack_timeout", found, 1);
    endtask

    task automatic settle();
        repeat (3) @(negedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, a1, a2;
        int c0, w0, r0, k0, d0;

        // Reset state
        repeat (3) @(negedge CLK);
        #1;
        check("rst_cs_n", CS_n, 1);
        check("rst_wr_rd", {WR_n, RD_n}, 2'b11);
        check("rst_busy_ack", {BUSY, ACK}, 2'b00);
        check("rst_rdata", RDATA, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        settle();

        // Write 8'hA5: CS_n 4 cycles, WR_n in cycles 2-3, ACK in cycle 5
        mon_db = 8'hA5; mon_db_chk = 1'b1;
        c0 = cs_cnt; w0 = wr_cnt; r0 = rd_cnt; k0 = ack_cnt; d0 = db_bad;
        start_xfer(1'b1, 8'hA5, acc);
        wait_ack(a1);
        settle();
        check("wr_cs_cycles", cs_cnt - c0, 4);
        check("wr_strobe_first", wr_start - acc + 1, 2);
        check("wr_strobe_last", wr_last - acc + 1, 3);
        check("wr_ack_latency", a1 - acc + 1, 5);
        check("wr_ack_count", ack_cnt - k0, 1);
        check("wr_rd_quiet", rd_cnt - r0, 0);
        check("wr_bus_value", db_bad - d0, 0);
        mon_db_chk = 1'b0;

        // Read, peripheral drives 8'h3C
        periph_data = 8'h3C;
        w0 = wr_cnt; r0 = rd_cnt;
        start_xfer(1'b0, 8'h00, acc);
        wait_ack(a1);
        check("rd_rdata_at_ack", RDATA, 8'h3C);
        settle();
        check("rd_strobe_cycles", rd_cnt - r0, 2);
        check("rd_wr_quiet", wr_cnt - w0, 0);
        check("rd_ack_latency", a1 - acc + 1, 5);

        // Back-to-back: write 8'h11 then read, REQ held high throughout
        periph_data = 8'h96;
        w0 = wr_cnt; r0 = rd_cnt; k0 = ack_cnt;
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; WDATA = 8'h11;
        @(posedge CLK);
        #1 acc = cyc;
        @(negedge CLK);
        WE = 1'b0; WDATA = 8'hFF;
        wait_ack(a1);
        @(negedge CLK);
        REQ = 1'b0;
        wait_ack(a2);
        settle();
        check("b2b_ack1_latency", a1 - acc + 1, 5);
        check("b2b_ack_spacing", a2 - a1, 5);
        check("b2b_strobe_gap", rd_start - wr_last, 4);
        check("b2b_wr_cycles", wr_cnt - w0, 2);
        check("b2b_rd_cycles", rd_cnt - r0, 2);
        check("b2b_ack_count", ack_cnt - k0, 2);
        check("b2b_rdata", RDATA, 8'h96);

        // Reset during the STROBE phase of a write
        periph_data = 8'h00;
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; WDATA = 8'h77;
        @(posedge CLK);
        @(negedge CLK);
        REQ = 1'b0;
        @(negedge CLK);
        #1 check("abort_pre_wr_n", WR_n, 0);
        #1 RST = 1'b1;
        #1;
        check("abort_wr_n", WR_n, 1);
        check("abort_cs_n", CS_n, 1);
        check("abort_busy_ack", {BUSY, ACK}, 2'b00);
        check("abort_bus", DataBus, 8'h00);
        check("abort_rdata", RDATA, 8'h00);
        k0 = ack_cnt;
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        #1;
        check("abort_no_ack", ack_cnt - k0, 0);
        check("abort_rdata_after", RDATA, 8'h00);

        // REQ pulsed with 8'hFF while busy is ignored
        mon_db = 8'h5A; mon_db_chk = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt; k0 = ack_cnt; d0 = db_bad;
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; WDATA = 8'h5A;
        @(posedge CLK);
        #1 acc = cyc;
        @(negedge CLK);
        REQ = 1'b0;
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b0; WDATA = 8'hFF;
        @(negedge CLK);
        REQ = 1'b0;
        wait_ack(a1);
        repeat (3) settle();
        check("ign_ack_count", ack_cnt - k0, 1);
        check("ign_ack_latency", a1 - acc + 1, 5);
        check("ign_bus_value", db_bad - d0, 0);
        check("ign_wr_cycles", wr_cnt - w0, 2);
        check("ign_rd_quiet", rd_cnt - r0, 0);
        mon_db_chk = 1'b0;

`ifdef BUS_INITIATOR_WAIT_EN
        // WAIT high for three edges at the end of STROBE
        periph_data = 8'hC3;
        r0 = rd_cnt;
        start_xfer(1'b0, 8'h00, acc);
        repeat (2) @(negedge CLK);
        wait_drv = 1'b1;
        repeat (3) @(negedge CLK);
        wait_drv = 1'b0;
        wait_ack(a1);
        settle();
        check("wait_rd_cycles", rd_cnt - r0, 5);
        check("wait_ack_latency", a1 - acc + 1, 8);
        check("wait_rdata", RDATA, 8'hC3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1: cycles from accept to strobe assertion (legal 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 2: minimum cycles a strobe is held low (legal 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1: cycles after strobe release before ACK (legal 1..15).
REQ-004 SHALL have ports as listed; one clock; reset asynchronous, active-high:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- REQ  in  1  transfer request from host logic.
- WE  in  1  1 = write cycle, 0 = read cycle; sampled with REQ.
- WDATA  in  8  write data; sampled with REQ.
- BUSY  out  1  transfer in progress; REQ ignored while high.
- ACK  out  1  one-cycle completion pulse.
- RDATA  out  8  last read data, held until the next read completes.
- WR_n  out  1  external write strobe, active-low.
- RD_n  out  1  external read strobe, active-low.
- CS_n  out  1  peripheral select, active-low.
- DataBus  inout  8  bidirectional data bus.
- WAIT  in  1  peripheral not-ready, active-high; present only with BUS_INITIATOR_WAIT_EN.

Function
REQ-005 SHALL implement FSM IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
REQ-006 SHALL accept REQ=1 at a rising edge only in IDLE or DONE, latching WE and WDATA; later changes to WE/WDATA SHALL be ignored.
REQ-007 SHALL assert BUSY in SETUP, STROBE and HOLD; BUSY=0 in IDLE and DONE.
REQ-008 SHALL hold CS_n=0 in SETUP, STROBE and HOLD; 1 otherwise.
REQ-009 SHALL assert WR_n=0 (write) or RD_n=0 (read) only in STROBE; both strobes never low together.
REQ-010 SHALL stay exactly SETUP_CYC cycles in SETUP, STROBE_CYC cycles in STROBE (without wait extension), HOLD_CYC cycles in HOLD, 1 cycle in DONE.
REQ-011 SHALL drive DataBus with latched WDATA in SETUP, STROBE and HOLD of a write; DataBus SHALL be high-Z at all other times, including every read cycle.
REQ-012 SHALL capture DataBus into RDATA at the edge leaving STROBE on a read; RDATA unchanged on writes.
REQ-013 SHALL pulse ACK=1 for exactly the DONE cycle; latency from accept edge to ACK cycle = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles.
REQ-014 SHALL start a new transfer directly from DONE if REQ=1 there (back-to-back, ACK and accept in same cycle); otherwise go to IDLE.
REQ-015 SHALL ignore REQ in SETUP, STROBE and HOLD; no queuing.
REQ-016 SHALL use one 4-bit down-counter reloaded on each state entry; no counter wrap-around reachable with legal parameters.

Reset
REQ-017 SHALL, on RST=1 at any time including mid-transfer, immediately force: state IDLE, WR_n=1, RD_n=1, CS_n=1, DataBus high-Z, BUSY=0, ACK=0, RDATA=8'h00.
REQ-018 SHALL not emit ACK for a transfer aborted by reset.

Configuration
REQ-019 SHALL, with BUS_INITIATOR_WAIT_EN defined, provide WAIT and remain in STROBE after the counter expires for as long as WAIT=1 at the rising edge; RDATA captured at the edge leaving STROBE.
REQ-020 SHALL, without BUS_INITIATOR_WAIT_EN, omit the WAIT port and use fixed timing per REQ-010.

Structure
REQ-021 SHALL place FSM state encodings, counter width (4) and parameter defaults in shared package bus_initiator_pkg.
REQ-022 SHALL contain one sub-module bus_phase_timer (load value, decrement, zero flag); tri-state drive stays in the top level.

Verification
REQ-023 Write 8'hA5, defaults -> CS_n low 4 cycles, WR_n low cycles 2-3 after accept, DataBus=8'hA5 throughout, ACK in cycle 5.
REQ-024 Read, peripheral drives 8'h3C -> RD_n low 2 cycles, RDATA=8'h3C from DONE cycle, DataBus never driven by block.
REQ-025 REQ held high for write 8'h11 then read -> second transfer accepted in the first ACK cycle, at least 1 cycle with strobes high between strobes.
REQ-026 RST=1 during STROBE of a write -> WR_n=1, CS_n=1, DataBus high-Z immediately, no ACK, RDATA=8'h00.
REQ-027 REQ pulsed with WDATA=8'hFF while BUSY=1 -> ignored; in-flight write data unchanged, only one ACK.
REQ-028 With BUS_INITIATOR_WAIT_EN, WAIT=1 for 3 edges at STROBE end -> RD_n low 5 cycles, ACK latency 8 cycles.
